write_back_buffer: RTL

Parametrised successor to the write-register selector: selects a destination register number from NSRC candidates and queues (destination, data) pairs in a DEPTH-entry FIFO. It drains one entry per cycle to the register-file write port whenever that port is ready. It sits between the multicycle control/datapath write-back stage and the register file. It also provides a youngest-match lookup so read stages can see pending, not-yet-written values.

---
 rtl/write_back_buffer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/write_back_buffer.sv
// Write-back buffer: picks a destination register from NSRC candidates, queues
// (dest, data) pairs in a DEPTH-entry FIFO and drains them to the register file.
module write_back_buffer #(
    parameter int NSRC   = 4,
    parameter int SEL_W  = 2,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NSRC*ADDR_W-1:0] DestIn,
    input  logic [SEL_W-1:0]       Selection,
    input  logic [DATA_W-1:0]      WriteData,
    input  logic                   Push,
    output logic                   PushReady,
    input  logic                   WrReady,
    output logic                   WrEn,
    output logic [ADDR_W-1:0]      WrAddr,
    output logic [DATA_W-1:0]      WrData,
    input  logic [ADDR_W-1:0]      LookupAddr,
    output logic                   LookupHit,
    output logic [DATA_W-1:0]      LookupData,
    output logic [CNT_W-1:0]       Count,
    output logic                   OverflowErr
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] r_mem_addr [DEPTH];
    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic              r_ovf;
    logic [ADDR_W-1:0] r_last_addr;
    logic [DATA_W-1:0] r_last_data;

    logic [ADDR_W-1:0] w_dest;
    logic              w_push_ready;
    logic              w_wr_en;
    logic              w_accept;
    logic              w_store;
    logic              w_pop;
    logic              w_hit;
    logic [DATA_W-1:0] w_lookup_data;

    // Out-of-range selections fall back to the last candidate.
    always_comb begin
        w_dest = DestIn[(NSRC-1)*ADDR_W +: ADDR_W];
        for (int i = 0; i < NSRC; i++) begin
            if (Selection == SEL_W'(i)) begin
                w_dest = DestIn[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign w_push_ready = (r_count != CNT_W'(DEPTH));
    assign w_wr_en      = (r_count != '0);
    assign w_accept     = Push && w_push_ready;
    assign w_store      = w_accept && (w_dest != '0);
    assign w_pop        = w_wr_en && WrReady;

    always_ff @(posedge CLK) begin
        if (w_store) begin
            r_mem_addr[r_tail] <= w_dest;
            r_mem_data[r_tail] <= WriteData;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_last_addr <= '0;
            r_last_data <= '0;
        end else begin
            if (w_store) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head      <= r_head + PTR_W'(1);
                r_last_addr <= r_mem_addr[r_head];
                r_last_data <= r_mem_data[r_head];
            end
            case ({w_store, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (Push && !w_push_ready) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Walk from head (oldest) to tail so the youngest match is the last assignment.
    always_comb begin
        logic [PTR_W-1:0] w_idx;
        w_idx         = '0;
        w_hit         = 1'b0;
        w_lookup_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PTR_W'(i);
            if ((CNT_W'(i) < r_count) && (LookupAddr != '0) &&
                (r_mem_addr[w_idx] == LookupAddr)) begin
                w_hit         = 1'b1;
                w_lookup_data = r_mem_data[w_idx];
            end
        end
    end

    assign PushReady   = w_push_ready;
    assign WrEn        = w_wr_en;
    assign WrAddr      = w_wr_en ? r_mem_addr[r_head] : r_last_addr;
    assign WrData      = w_wr_en ? r_mem_data[r_head] : r_last_data;
    assign LookupHit   = w_hit;
    assign LookupData  = w_lookup_data;
    assign Count       = r_count;
    assign OverflowErr = r_ovf;

endmodule
